// File: rtl/xoodyak_cmd_sequencer.sv
// xoodyak_cmd_sequencer: plays a loadable table of opmode/hold entries into the
// Xoodyak core, with a per-opmode data table feeding input_data.
module xoodyak_cmd_sequencer #(
    parameter int DEPTH  = 128,
    parameter int DATA_W = 352,
    parameter int OP_W   = 6,
    parameter int HOLD_W = 4,
    parameter int NDATA  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              eph1,
    input  logic              reset,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_waddr,
    input  logic [OP_W-1:0]   cmd_wop,
    input  logic [HOLD_W-1:0] cmd_whold,
    input  logic              dat_we,
    input  logic [3:0]        dat_waddr,
    input  logic [DATA_W-1:0] dat_wdata,
    input  logic [AW:0]       seq_len,
    input  logic              loop_en,
    input  logic              start,
    input  logic              abort,
    output logic [OP_W-1:0]   opmode,
    output logic [DATA_W-1:0] input_data,
    output logic              opmode_valid,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     cur_idx,
    output logic [15:0]       loop_cnt
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_LEN = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_IDX = AW'(1);
    localparam logic [4:0]    NDATA_L = 5'(NDATA);

    logic [OP_W-1:0]   cmd_op   [DEPTH];
    logic [HOLD_W-1:0] cmd_hold [DEPTH];
    logic [DATA_W-1:0] dat_tab  [NDATA];

    state_t            state, state_d;
    logic [AW:0]       len, len_d;
    logic [HOLD_W-1:0] hold_ctr, hold_ctr_d;
    logic [OP_W-1:0]   opmode_d;
    logic [DATA_W-1:0] input_data_d;
    logic              opmode_valid_d;
    logic              busy_d;
    logic              done_d;
    logic [AW-1:0]     cur_idx_d;
    logic [15:0]       loop_cnt_d;

    logic              load_en;
    logic [AW-1:0]     load_idx;
    logic [3:0]        data_idx;
    logic              last_entry;

    // Command table: cleared by reset, written at the edge so a same-cycle load sees the old entry
    always_ff @(posedge eph1) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                cmd_op[i]   <= '0;
                cmd_hold[i] <= '0;
            end
        end else if (cmd_we) begin
            cmd_op[cmd_waddr]   <= cmd_wop;
            cmd_hold[cmd_waddr] <= cmd_whold;
        end
    end

    // Data table: cleared by reset, out-of-range write addresses are dropped
    always_ff @(posedge eph1) begin
        if (reset) begin
            for (int i = 0; i < NDATA; i++) begin
                dat_tab[i] <= '0;
            end
        end else if (dat_we && ({1'b0, dat_waddr} < NDATA_L)) begin
            dat_tab[dat_waddr] <= dat_wdata;
        end
    end

    assign last_entry = ({1'b0, cur_idx} == (len - ONE_LEN));

    // Next-state and next-output decode; an entry load overrides the presented fields
    always_comb begin
        state_d        = state;
        len_d          = len;
        hold_ctr_d     = hold_ctr;
        opmode_d       = opmode;
        input_data_d   = input_data;
        opmode_valid_d = opmode_valid;
        busy_d         = busy;
        done_d         = 1'b0;
        cur_idx_d      = cur_idx;
        loop_cnt_d     = loop_cnt;
        load_en        = 1'b0;
        load_idx       = '0;
        data_idx       = '0;

        case (state)
            IDLE: begin
                if (start && !abort && (seq_len != '0)) begin
                    len_d      = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
                    state_d    = RUN;
                    load_en    = 1'b1;
                    load_idx   = '0;
                    loop_cnt_d = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d        = IDLE;
                    opmode_d       = '0;
                    opmode_valid_d = 1'b0;
                    busy_d         = 1'b0;
                end else if (hold_ctr != '0) begin
                    hold_ctr_d = hold_ctr - 1'b1;
                end else if (!last_entry) begin
                    load_en  = 1'b1;
                    load_idx = cur_idx + ONE_IDX;
                end else if (loop_en) begin
                    load_en  = 1'b1;
                    load_idx = '0;
                    if (loop_cnt != 16'hFFFF) begin
                        loop_cnt_d = loop_cnt + 16'd1;
                    end
                end else begin
                    state_d        = IDLE;
                    opmode_d       = '0;
                    opmode_valid_d = 1'b0;
                    busy_d         = 1'b0;
                    done_d         = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_en) begin
            cur_idx_d      = load_idx;
            opmode_d       = cmd_op[load_idx];
            hold_ctr_d     = cmd_hold[load_idx];
            data_idx       = cmd_op[load_idx][3:0];
            input_data_d   = ({1'b0, data_idx} < NDATA_L) ? dat_tab[data_idx] : '0;
            opmode_valid_d = 1'b1;
            busy_d         = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge eph1) begin
        if (reset) begin
            state        <= IDLE;
            len          <= '0;
            hold_ctr     <= '0;
            opmode       <= '0;
            input_data   <= '0;
            opmode_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cur_idx      <= '0;
            loop_cnt     <= '0;
        end else begin
            state        <= state_d;
            len          <= len_d;
            hold_ctr     <= hold_ctr_d;
            opmode       <= opmode_d;
            input_data   <= input_data_d;
            opmode_valid <= opmode_valid_d;
            busy         <= busy_d;
            done         <= done_d;
            cur_idx      <= cur_idx_d;
            loop_cnt     <= loop_cnt_d;
        end
    end

endmodule

// File: tb/tb_xoodyak_cmd_sequencer.sv
// tb_xoodyak_cmd_sequencer: scoreboard bench; expected per-cycle outputs are
// queued from a shadow copy of the tables and popped at each falling edge.
module tb_xoodyak_cmd_sequencer;

    localparam int DEPTH  = 128;
    localparam int DATA_W = 352;
    localparam int OP_W   = 6;
    localparam int HOLD_W = 4;
    localparam int NDATA  = 16;
    localparam int AW     = 7;

    logic              eph1 = 1'b0;
    logic              reset;
    logic              cmd_we;
    logic [AW-1:0]     cmd_waddr;
    logic [OP_W-1:0]   cmd_wop;
    logic [HOLD_W-1:0] cmd_whold;
    logic              dat_we;
    logic [3:0]        dat_waddr;
    logic [DATA_W-1:0] dat_wdata;
    logic [AW:0]       seq_len;
    logic              loop_en;
    logic              start;
    logic              abort;
    logic [OP_W-1:0]   opmode;
    logic [DATA_W-1:0] input_data;
    logic              opmode_valid;
    logic              busy;
    logic              done;
    logic [AW-1:0]     cur_idx;
    logic [15:0]       loop_cnt;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic              valid;
        logic              busy;
        logic              done;
        logic [AW-1:0]     idx;
        logic [15:0]       lc;
        logic [DATA_W-1:0] data;
    } obs_t;

    obs_t exp_q[$];
    obs_t last_e;
    obs_t got;
    obs_t want;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc;

    logic [OP_W-1:0]   sh_op   [DEPTH];
    logic [HOLD_W-1:0] sh_hold [DEPTH];
    logic [DATA_W-1:0] sh_dat  [NDATA];

    localparam logic [DATA_W-1:0] NONCE = {128'h494a4b4c4d4e4f404142434445464748, 224'h0};
    localparam logic [DATA_W-1:0] D2A   = {32'hA2A2A2A2, 320'h1};
    localparam logic [DATA_W-1:0] D2B   = {32'hB2B2B2B2, 320'h2};
    localparam logic [DATA_W-1:0] D3    = {32'hC3C3C3C3, 320'h3};

    xoodyak_cmd_sequencer dut (
        .eph1         (eph1),
        .reset        (reset),
        .cmd_we       (cmd_we),
        .cmd_waddr    (cmd_waddr),
        .cmd_wop      (cmd_wop),
        .cmd_whold    (cmd_whold),
        .dat_we       (dat_we),
        .dat_waddr    (dat_waddr),
        .dat_wdata    (dat_wdata),
        .seq_len      (seq_len),
        .loop_en      (loop_en),
        .start        (start),
        .abort        (abort),
        .opmode       (opmode),
        .input_data   (input_data),
        .opmode_valid (opmode_valid),
        .busy         (busy),
        .done         (done),
        .cur_idx      (cur_idx),
        .loop_cnt     (loop_cnt)
    );

    // Free-running clock
    always #5 eph1 = ~eph1;

    function automatic obs_t observe();
        obs_t o;
        o.op    = opmode;
        o.valid = opmode_valid;
        o.busy  = busy;
        o.done  = done;
        o.idx   = cur_idx;
        o.lc    = loop_cnt;
        o.data  = input_data;
        return o;
    endfunction

    task automatic write_cmd(input int addr, input logic [OP_W-1:0] op, input logic [HOLD_W-1:0] hold);
        cmd_we    = 1'b1;
        cmd_waddr = AW'(addr);
        cmd_wop   = op;
        cmd_whold = hold;
        @(negedge eph1);
        cmd_we = 1'b0;
        sh_op[addr]   = op;
        sh_hold[addr] = hold;
    endtask

    task automatic write_dat(input int addr, input logic [DATA_W-1:0] d);
        dat_we    = 1'b1;
        dat_waddr = 4'(addr);
        dat_wdata = d;
        @(negedge eph1);
        dat_we = 1'b0;
        sh_dat[addr] = d;
    endtask

    task automatic push_entry(input int idx, input int lc);
        obs_t e;
        e.op    = sh_op[idx];
        e.valid = 1'b1;
        e.busy  = 1'b1;
        e.done  = 1'b0;
        e.idx   = AW'(idx);
        e.lc    = 16'(lc);
        e.data  = sh_dat[sh_op[idx][3:0]];
        for (int h = 0; h <= int'(sh_hold[idx]); h++) exp_q.push_back(e);
        last_e = e;
    endtask

    task automatic push_pass(input int len, input int lc);
        for (int i = 0; i < len; i++) push_entry(i, lc);
    endtask

    task automatic push_end(input bit with_done);
        obs_t e;
        e       = last_e;
        e.op    = '0;
        e.valid = 1'b0;
        e.busy  = 1'b0;
        e.done  = with_done;
        exp_q.push_back(e);
        if (with_done) begin
            e.done = 1'b0;
            exp_q.push_back(e);
        end
        last_e = e;
    endtask

    task automatic test_reset();
        n_tests++;
        if (observe() !== obs_t'('0)) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got %h, want 0", observe());
        end
        start = 1'b1; seq_len = 8'd3;
        cmd_we = 1'b1; cmd_waddr = '0; cmd_wop = 6'h05; cmd_whold = 4'd2;
        @(negedge eph1);
        n_tests++;
        if (observe() !== obs_t'('0)) begin
            n_fail++;
            $display("[TB] FAIL reset_override: got %h, want 0", observe());
        end
        reset = 1'b0; cmd_we = 1'b0;
        seq_len = 8'd1; loop_en = 1'b0; start = 1'b1;
        push_pass(1, 0);
        push_end(1'b1);
        cyc = 0;
        while (exp_q.size() != 0) begin
            @(negedge eph1);
            cyc++;
            got = observe(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("[TB] FAIL after_reset cyc %0d: got op=%h v=%b b=%b d=%b idx=%0d lc=%0d data=%h, want op=%h v=%b b=%b d=%b idx=%0d lc=%0d data=%h",
                         cyc, got.op, got.valid, got.busy, got.done, got.idx, got.lc, got.data,
                         want.op, want.valid, want.busy, want.done, want.idx, want.lc, want.data);
            end
            start = 1'b0;
        end
    endtask

    task automatic test_basic(input logic [HOLD_W-1:0] hold, input string name);
        for (int i = 0; i < 3; i++) write_cmd(i, OP_W'(i), hold);
        seq_len = 8'd3; loop_en = 1'b0; start = 1'b1;
        push_pass(3, 0);
        push_end(1'b1);
        cyc = 0;
        while (exp_q.size() != 0) begin
            @(negedge eph1);
            cyc++;
            got = observe(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("[TB] FAIL %s cyc %0d: got op=%h v=%b b=%b d=%b idx=%0d lc=%0d data=%h, want op=%h v=%b b=%b d=%b idx=%0d lc=%0d data=%h",
                         name, cyc, got.op, got.valid, got.busy, got.done, got.idx, got.lc, got.data,
                         want.op, want.valid, want.busy, want.done, want.idx, want.lc, want.data);
            end
            start = 1'b0;
        end
    endtask

    task automatic test_loop();
        write_cmd(0, 6'h00, 4'd1);
        write_cmd(1, 6'h01, 4'd1);
        seq_len = 8'd2; loop_en = 1'b1; start = 1'b1;
        for (int k = 0; k < 5; k++) push_pass(2, k);
        push_end(1'b1);
        cyc = 0;
        while (exp_q.size() != 0) begin
            @(negedge eph1);
            cyc++;
            got = observe(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("[TB] FAIL loop cyc %0d: got op=%h v=%b b=%b d=%b idx=%0d lc=%0d data=%h, want op=%h v=%b b=%b d=%b idx=%0d lc=%0d data=%h",
                         cyc, got.op, got.valid, got.busy, got.done, got.idx, got.lc, got.data,
                         want.op, want.valid, want.busy, want.done, want.idx, want.lc, want.data);
            end
            start = 1'b0;
            if (cyc == 20) loop_en = 1'b0;
        end
    endtask

    task automatic test_abort();
        obs_t e;
        for (int i = 0; i < 3; i++) write_cmd(i, OP_W'(i), 4'd3);
        seq_len = 8'd3; loop_en = 1'b0; start = 1'b1;
        push_entry(0, 0);
        e = '0;
        e.op = sh_op[1]; e.valid = 1'b1; e.busy = 1'b1; e.idx = AW'(1);
        e.data = sh_dat[sh_op[1][3:0]];
        exp_q.push_back(e);
        last_e = e;
        push_end(1'b0);
        exp_q.push_back(last_e);
        exp_q.push_back(last_e);
        cyc = 0;
        while (exp_q.size() != 0) begin
            @(negedge eph1);
            cyc++;
            got = observe(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("[TB] FAIL abort cyc %0d: got op=%h v=%b b=%b d=%b idx=%0d lc=%0d data=%h, want op=%h v=%b b=%b d=%b idx=%0d lc=%0d data=%h",
                         cyc, got.op, got.valid, got.busy, got.done, got.idx, got.lc, got.data,
                         want.op, want.valid, want.busy, want.done, want.idx, want.lc, want.data);
            end
            start = 1'b0; abort = 1'b0;
            if (cyc == 5) abort = 1'b1;
            if (cyc == 6) begin abort = 1'b1; start = 1'b1; end
        end
    endtask

    task automatic test_write_during_run();
        write_cmd(0, 6'h02, 4'd3);
        write_cmd(1, 6'h01, 4'd0);
        write_dat(2, D2A);
        write_dat(3, D3);
        seq_len = 8'd2; loop_en = 1'b1; start = 1'b1;
        push_entry(0, 0);
        push_entry(1, 0);
        sh_dat[2]  = D2B;
        sh_op[1]   = 6'h03;
        sh_hold[1] = 4'd1;
        push_entry(0, 1);
        push_entry(1, 1);
        push_end(1'b1);
        cyc = 0;
        while (exp_q.size() != 0) begin
            @(negedge eph1);
            cyc++;
            got = observe(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("[TB] FAIL write_in_run cyc %0d: got op=%h v=%b b=%b d=%b idx=%0d lc=%0d data=%h, want op=%h v=%b b=%b d=%b idx=%0d lc=%0d data=%h",
                         cyc, got.op, got.valid, got.busy, got.done, got.idx, got.lc, got.data,
                         want.op, want.valid, want.busy, want.done, want.idx, want.lc, want.data);
            end
            start = 1'b0; dat_we = 1'b0; cmd_we = 1'b0;
            if (cyc == 2) begin dat_we = 1'b1; dat_waddr = 4'd2; dat_wdata = D2B; end
            if (cyc == 4) begin cmd_we = 1'b1; cmd_waddr = AW'(1); cmd_wop = 6'h03; cmd_whold = 4'd1; end
            if (cyc == 11) loop_en = 1'b0;
        end
    endtask

    task automatic test_len_edges();
        seq_len = 8'd0; loop_en = 1'b0; start = 1'b1;
        exp_q.push_back(last_e);
        exp_q.push_back(last_e);
        cyc = 0;
        while (exp_q.size() != 0) begin
            @(negedge eph1);
            cyc++;
            got = observe(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("[TB] FAIL len_zero cyc %0d: got op=%h v=%b b=%b d=%b idx=%0d lc=%0d, want op=%h v=%b b=%b d=%b idx=%0d lc=%0d",
                         cyc, got.op, got.valid, got.busy, got.done, got.idx, got.lc,
                         want.op, want.valid, want.busy, want.done, want.idx, want.lc);
            end
            start = 1'b0;
        end
        seq_len = 8'(DEPTH + 1); start = 1'b1;
        push_pass(DEPTH, 0);
        push_end(1'b1);
        cyc = 0;
        while (exp_q.size() != 0) begin
            @(negedge eph1);
            cyc++;
            got = observe(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("[TB] FAIL len_over cyc %0d: got op=%h v=%b b=%b d=%b idx=%0d lc=%0d, want op=%h v=%b b=%b d=%b idx=%0d lc=%0d",
                         cyc, got.op, got.valid, got.busy, got.done, got.idx, got.lc,
                         want.op, want.valid, want.busy, want.done, want.idx, want.lc);
            end
            start = 1'b0;
        end
    endtask

    task automatic test_reset_midrun();
        seq_len = 8'd3; loop_en = 1'b0; start = 1'b1;
        push_pass(3, 0);
        cyc = 0;
        while (exp_q.size() != 0) begin
            @(negedge eph1);
            cyc++;
            got = observe(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("[TB] FAIL reset_midrun cyc %0d: got op=%h v=%b b=%b d=%b idx=%0d lc=%0d data=%h, want op=%h v=%b b=%b d=%b idx=%0d lc=%0d data=%h",
                         cyc, got.op, got.valid, got.busy, got.done, got.idx, got.lc, got.data,
                         want.op, want.valid, want.busy, want.done, want.idx, want.lc, want.data);
            end
            start = 1'b0; reset = 1'b0;
            if (cyc == 3) begin
                reset = 1'b1;
                exp_q.delete();
                exp_q.push_back(obs_t'('0));
            end
        end
        for (int i = 0; i < DEPTH; i++) begin sh_op[i] = '0; sh_hold[i] = '0; end
        for (int i = 0; i < NDATA; i++) sh_dat[i] = '0;
        last_e = '0;
        seq_len = 8'd3; start = 1'b1;
        push_pass(3, 0);
        push_end(1'b1);
        cyc = 0;
        while (exp_q.size() != 0) begin
            @(negedge eph1);
            cyc++;
            got = observe(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("[TB] FAIL tables_cleared cyc %0d: got op=%h v=%b b=%b d=%b idx=%0d lc=%0d data=%h, want op=%h v=%b b=%b d=%b idx=%0d lc=%0d data=%h",
                         cyc, got.op, got.valid, got.busy, got.done, got.idx, got.lc, got.data,
                         want.op, want.valid, want.busy, want.done, want.idx, want.lc, want.data);
            end
            start = 1'b0;
        end
    endtask

    // Test sequence
    initial begin
        reset = 1'b1;
        cmd_we = 1'b0; cmd_waddr = '0; cmd_wop = '0; cmd_whold = '0;
        dat_we = 1'b0; dat_waddr = '0; dat_wdata = '0;
        seq_len = '0; loop_en = 1'b0; start = 1'b0; abort = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin sh_op[i] = '0; sh_hold[i] = '0; end
        for (int i = 0; i < NDATA; i++) sh_dat[i] = '0;
        last_e = '0;
        repeat (2) @(negedge eph1);
        test_reset();
        write_dat(1, NONCE);
        test_basic(4'd3, "basic_hold3");
        test_basic(4'd0, "basic_hold0");
        test_loop();
        test_abort();
        test_write_during_run();
        test_len_edges();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xoodyak_cmd_sequencer.md
Name: xoodyak_cmd_sequencer

Overview:
- Programmable command sequencer that drives the opmode and input_data ports of the Xoodyak core.
- Replaces hard-wired opmode/data stimulus tables with loadable tables:
  - a command table of opmode plus per-entry hold count;
  - a data table indexed by opmode[3:0].
- Plays a programmed sequence once or looping, with start/abort control and busy/done status.
- Sits between a host/config interface and xoodyak_build; usable in silicon bring-up and in benches.

Parameters:
DEPTH, 128, number of command-table entries (power of 2, ≥2); AW = $clog2(DEPTH)
DATA_W, 352, width of the data-table word and input_data
OP_W, 6, opmode width
HOLD_W, 4, per-entry hold-count width
NDATA, 16, data-table entries (≤16)

Ports:
eph1  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_we  in  1  command-table write strobe
cmd_waddr  in  AW  command-table write address
cmd_wop  in  OP_W  opmode written to entry
cmd_whold  in  HOLD_W  hold count written to entry
dat_we  in  1  data-table write strobe
dat_waddr  in  4  data-table write address; ignored if ≥NDATA
dat_wdata  in  DATA_W  data word written
seq_len  in  AW+1  entries to play, sampled at start
loop_en  in  1  1 = wrap to entry 0 after last entry; sampled at each wrap point
start  in  1  begin sequence (honoured only in IDLE)
abort  in  1  terminate sequence
opmode  out  OP_W  command to core
input_data  out  DATA_W  data to core
opmode_valid  out  1  high while an entry is being presented
busy  out  1  high in RUN
done  out  1  one-cycle pulse on normal completion
cur_idx  out  AW  index of entry currently presented
loop_cnt  out  16  completed wraps, saturating at 16'hFFFF

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Both tables cleared to 0.
  - Reset asserted in any state takes effect at the next edge and overrides start, abort and writes.
- Tables:
  - Writes take effect at the edge.
  - Loading an entry reads the pre-write value if written in the same cycle.
  - Writes are allowed while busy and are seen the next time that entry is loaded.
- FSM states: IDLE, RUN.
- IDLE:
  - On start with seq_len≠0: latch len = min(seq_len, DEPTH).
  - Next cycle enters RUN with cur_idx=0, opmode=cmd[0].op, input_data=data[cmd[0].op[3:0]] (0 if index ≥NDATA), hold_ctr=cmd[0].hold, opmode_valid=1, busy=1.
  - start with seq_len=0 is ignored; no done pulse.
- RUN:
  - Each entry is presented for hold+1 cycles; hold=0 means 1 cycle.
  - If hold_ctr≠0: hold_ctr decrements.
  - If hold_ctr=0 and cur_idx<len-1: load entry cur_idx+1 next cycle, with no bubble.
  - If hold_ctr=0 and cur_idx=len-1, with loop_en=1: load entry 0 next cycle and increment loop_cnt (saturating).
  - If hold_ctr=0 and cur_idx=len-1, with loop_en=0: next cycle go to IDLE with opmode=0, input_data unchanged, opmode_valid=0, busy=0, done=1 for exactly that cycle.
- input_data is captured at entry load. Data-table writes during a hold do not alter it.
- start while in RUN is ignored.
- abort:
  - In RUN: next cycle IDLE, opmode=0, opmode_valid=0, busy=0, done=0.
  - abort wins over an end-of-sequence transition in the same cycle.
  - abort in IDLE is a no-op, and wins over a simultaneous start.
- loop_cnt and cur_idx:
  - Both clear at each accepted start.
  - Both hold their values in IDLE after done/abort.
- Latency: start edge to first valid opmode is 1 cycle.
- Sequence length: total cycles = Σ(hold_i+1) over len entries.

Test Plan:
- Program cmd[0..2] = {0x00 h3, 0x01 h3, 0x02 h3}, data[1]=nonce 0x494a…48<<224, seq_len=3, start → opmode 0x00 ×4, 0x01 ×4 with input_data=nonce, 0x02 ×4; done pulses on cycle 13 after start; busy high cycles 1–12.
- Same table, hold=0 on all entries → opmodes 0,1,2 on consecutive cycles, done at cycle 4; no gaps.
- seq_len=2, loop_en=1, hold=1; run 20 cycles then drop loop_en → loop_cnt increments every 4 cycles; sequence ends after the wrap that sees loop_en=0; done=1 once.
- Abort in cycle 5 of a 12-cycle sequence, with abort and start together in the following cycle → opmode=0 and valid=0 the next cycle, no done pulse, start ignored, cur_idx frozen at 1.
- Write data[2] mid-hold of an opmode-0x02 entry, and write cmd[1] on the same cycle it is loaded → input_data keeps the old value until the next load; entry 1 presents the old opmode; the new values appear on the next loop.
- seq_len=0 start → stays IDLE, no done. seq_len=DEPTH+1 → plays exactly DEPTH entries. Reset asserted mid-RUN → all outputs 0 the next cycle and tables cleared.
